ps2_packet_ctrl: RTL and testbench

//  Sequences a PS/2 mouse byte stream into 3-byte packets. It hunts for the sync byte
//  (bit[3]=1) and assembles 24-bit packets. Packets go to the host over valid/ready

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_gap_timer.sv | 30 +++
 rtl/ps2_packet_ctrl.sv | 127 ++++++++++++
 tb/tb_ps2_packet_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 packet framer.
// Framer states, packet size and the sync bit position.
package ps2_pkg;

  typedef enum logic [1:0] {
    HUNT,
    GOT1,
    GOT2
  } ps2_state_t;

  localparam int PKT_BYTES = 3;
  localparam int SYNC_BIT  = 3;
  localparam int PKT_W     = PKT_BYTES * 8;

endpackage

// File: rtl/ps2_gap_timer.sv
// Inter-byte gap counter for the packet framer.
// Ports: clk, reset (async high), clear, tick, expired (count at limit).
module ps2_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/ps2_packet_ctrl.sv
// Frames a PS/2 mouse byte stream into 3-byte packets for the host.
// Ports: clk, reset, in_valid/in_byte, out_valid/out_ready/out_packet,
// overflow and timeout_err pulses, saturating drop_count.
module ps2_packet_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_packet,
  output logic             overflow,
  output logic             timeout_err,
  output logic [CNT_W-1:0] drop_count
);

  ps2_state_t state, state_n;

  logic [7:0] byte0, byte1;
  logic       cap0, cap1, complete;
  logic       expired, timeout;
  logic       load, drop;
  logic       t_clear, t_tick;

  assign t_clear = in_valid || (state == HUNT);
  assign t_tick  = !in_valid && (state != HUNT);

  ps2_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap (
    .clk    (clk),
    .reset  (reset),
    .clear  (t_clear),
    .tick   (t_tick),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    cap0     = 1'b0;
    cap1     = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      HUNT: begin
        if (in_valid && in_byte[SYNC_BIT]) begin
          state_n = GOT1;
          cap0    = 1'b1;
        end
      end
      GOT1: begin
        if (in_valid) begin
          state_n = GOT2;
          cap1    = 1'b1;
        end else if (expired) begin
          state_n = HUNT;
          timeout = 1'b1;
        end
      end
      GOT2: begin
        if (in_valid) begin
          state_n  = HUNT;
          complete = 1'b1;
        end else if (expired) begin
          state_n = HUNT;
          timeout = 1'b1;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // A completion may reuse the output slot if it is empty or
  // being drained by the host in the same cycle.
  assign load = complete && (!out_valid || out_ready);
  assign drop = complete && out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte0 <= '0;
      byte1 <= '0;
    end else begin
      if (cap0) byte0 <= in_byte;
      if (cap1) byte1 <= in_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_packet <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_packet <= {byte0, byte1, in_byte};
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      overflow    <= drop;
      timeout_err <= timeout;
      if ((drop || timeout) && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_packet_ctrl.sv
// Directed self-checking bench for ps2_packet_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ps2_packet_ctrl;

  localparam int T     = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             out_valid;
  logic             out_ready;
  logic [23:0]      out_packet;
  logic             overflow;
  logic             timeout_err;
  logic [CNT_W-1:0] drop_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_packet_ctrl #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_packet (out_packet),
    .overflow   (overflow),
    .timeout_err(timeout_err),
    .drop_count (drop_count)
  );

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    idle(2);
    tests++;
    if ({out_valid, out_packet, overflow, timeout_err, drop_count}
        !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b p=%h o=%b t=%b d=%0d exp 0",
               out_valid, out_packet, overflow, timeout_err, drop_count);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    do_reset();
    send(8'h08);
    send(8'h11);
    send(8'h22);
    tests++;
    if (out_valid !== 1'b1 || out_packet !== 24'h081122) begin
      fails++;
      $display("FAIL basic_pkt: got v=%b p=%h exp v=1 p=081122",
               out_valid, out_packet);
    end
    idle(1);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_held1: got v=%b exp 0", out_valid);
    end
  endtask

  task automatic test_hunt;
    int errs;
    errs = 0;
    do_reset();
    send(8'h00);
    errs += int'(overflow | timeout_err | out_valid);
    send(8'h07);
    errs += int'(overflow | timeout_err | out_valid);
    send(8'h2C);
    send(8'h01);
    errs += int'(out_valid);
    send(8'h02);
    tests++;
    if (out_valid !== 1'b1 || out_packet !== 24'h2C0102) begin
      fails++;
      $display("FAIL hunt_pkt: got v=%b p=%h exp v=1 p=2c0102",
               out_valid, out_packet);
    end
    tests++;
    if (errs != 0 || overflow !== 1'b0 || timeout_err !== 1'b0
        || drop_count !== '0) begin
      fails++;
      $display("FAIL hunt_noerr: got errs=%0d d=%0d exp 0",
               errs, drop_count);
    end
  endtask

  task automatic test_overflow;
    do_reset();
    out_ready = 1'b0;
    send(8'h88);
    send(8'h01);
    send(8'h02);
    send(8'h09);
    send(8'h03);
    send(8'h04);
    tests++;
    if (overflow !== 1'b1 || drop_count !== 4'd1
        || out_packet !== 24'h880102 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_pulse: got o=%b d=%0d p=%h exp o=1 d=1 p=880102",
               overflow, drop_count, out_packet);
    end
    idle(1);
    tests++;
    if (overflow !== 1'b0 || out_packet !== 24'h880102) begin
      fails++;
      $display("FAIL ovf_hold: got o=%b p=%h exp o=0 p=880102",
               overflow, out_packet);
    end
    out_ready = 1'b1;
    idle(1);
    tests++;
    if (out_valid !== 1'b0 || drop_count !== 4'd1) begin
      fails++;
      $display("FAIL ovf_accept: got v=%b d=%0d exp v=0 d=1",
               out_valid, drop_count);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    do_reset();
    send(8'h08);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3 * T) begin
      @(negedge clk);
      n++;
      seen = timeout_err;
    end
    tests++;
    if (!seen || n != T) begin
      fails++;
      $display("FAIL timeout_when: got seen=%b after %0d exp after %0d",
               seen, n, T);
    end
    idle(1);
    tests++;
    if (timeout_err !== 1'b0 || drop_count !== 4'd1) begin
      fails++;
      $display("FAIL timeout_pulse: got t=%b d=%0d exp t=0 d=1",
               timeout_err, drop_count);
    end
    send(8'h18);
    send(8'h01);
    send(8'h02);
    tests++;
    if (out_valid !== 1'b1 || out_packet !== 24'h180102) begin
      fails++;
      $display("FAIL timeout_resync: got v=%b p=%h exp v=1 p=180102",
               out_valid, out_packet);
    end
  endtask

  task automatic test_timeout_edge;
    int errs;
    errs = 0;
    do_reset();
    send(8'h08);
    for (int i = 0; i < T - 1; i++) begin
      @(negedge clk);
      errs += int'(timeout_err);
    end
    send(8'h01);
    errs += int'(timeout_err);
    send(8'h02);
    errs += int'(timeout_err);
    tests++;
    if (errs != 0 || out_packet !== 24'h080102 || out_valid !== 1'b1
        || drop_count !== '0) begin
      fails++;
      $display("FAIL timeout_edge: got errs=%0d p=%h d=%0d exp 0 080102 0",
               errs, out_packet, drop_count);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    out_ready = 1'b0;
    send(8'h08);
    send(8'h0A);
    send(8'h0B);
    send(8'h3C);
    send(8'h0D);
    out_ready = 1'b1;
    send(8'h0E);
    tests++;
    if (overflow !== 1'b0 || out_valid !== 1'b1
        || out_packet !== 24'h3C0D0E) begin
      fails++;
      $display("FAIL b2b_reload: got o=%b v=%b p=%h exp o=0 v=1 p=3c0d0e",
               overflow, out_valid, out_packet);
    end
    idle(1);
    tests++;
    if (out_valid !== 1'b0 || drop_count !== '0) begin
      fails++;
      $display("FAIL b2b_drain: got v=%b d=%0d exp v=0 d=0",
               out_valid, drop_count);
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    out_ready = 1'b0;
    send(8'h08);
    send(8'h11);
    send(8'h22);
    send(8'h08);
    send(8'h01);
    send(8'h02);
    send(8'h2C);
    send(8'h01);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_packet, overflow, timeout_err, drop_count}
        !== '0) begin
      fails++;
      $display("FAIL async_reset: got v=%b p=%h o=%b t=%b d=%0d exp 0",
               out_valid, out_packet, overflow, timeout_err, drop_count);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    idle(1);
    send(8'h02);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hunt: got v=%b exp 0", out_valid);
    end
    send(8'h18);
    send(8'h05);
    send(8'h06);
    tests++;
    if (out_valid !== 1'b1 || out_packet !== 24'h180506) begin
      fails++;
      $display("FAIL reset_fresh: got v=%b p=%h exp v=1 p=180506",
               out_valid, out_packet);
    end
  endtask

  task automatic test_saturate;
    do_reset();
    out_ready = 1'b0;
    send(8'h08);
    send(8'h00);
    send(8'h00);
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      send(8'h08);
      send(8'h55);
      send(8'hAA);
    end
    idle(1);
    tests++;
    if (drop_count !== 4'hF || out_packet !== 24'h080000) begin
      fails++;
      $display("FAIL saturate: got d=%0d p=%h exp d=15 p=080000",
               drop_count, out_packet);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hunt();
    test_overflow();
    test_timeout();
    test_timeout_edge();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
